// File: rtl/counter_pkg.sv
// Shared types for the multi-channel counter.
// Mode encoding and field widths used by counter_ch and counter_multi.
package counter_pkg;

    typedef enum logic [1:0] {
        CNT_WRAP    = 2'd0,
        CNT_SAT     = 2'd1,
        CNT_ONESHOT = 2'd2,
        CNT_RSVD    = 2'd3
    } cnt_mode_e;

    localparam int CNT_MODE_W = 2;

endpackage

// File: rtl/counter_ch.sv
// One counter channel: count, terminal pulse, oneshot done and sticky overflow.
// Priority per edge is clr > load > en.
module counter_ch
    import counter_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         en_i,
    input  logic         clr_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         dir_i,
    input  cnt_mode_e    mode_i,
    input  logic [W-1:0] max_i,
    output logic [W-1:0] cnt_o,
    output logic         tc_o,
    output logic         done_o,
    output logic         ovf_o
);

    logic [W-1:0] cnt_q, cnt_d;
    logic         tc_q, tc_d;
    logic         done_q, done_d;
    logic         ovf_q, ovf_d;
    logic         term;

    assign term = dir_i ? (cnt_q >= max_i) : (cnt_q == '0);

    always_comb begin
        cnt_d  = cnt_q;
        tc_d   = 1'b0;
        done_d = done_q;
        ovf_d  = ovf_q;
        if (clr_i) begin
            cnt_d  = '0;
            done_d = 1'b0;
            ovf_d  = 1'b0;
        end else if (load_i) begin
            cnt_d  = (load_val_i > max_i) ? max_i : load_val_i;
            done_d = 1'b0;
        end else if (en_i && !done_q) begin
            if (!term) begin
                cnt_d = dir_i ? cnt_q + 1'b1 : cnt_q - 1'b1;
            end else begin
                tc_d  = 1'b1;
                ovf_d = 1'b1;
                // SAT and ONESHOT clamp to max so a lowered max pulls count down
                case (mode_i)
                    CNT_SAT: begin
                        cnt_d = dir_i ? max_i : '0;
                    end
                    CNT_ONESHOT: begin
                        cnt_d  = dir_i ? max_i : '0;
                        done_d = 1'b1;
                    end
                    default: begin
                        cnt_d = dir_i ? '0 : max_i;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q  <= '0;
            tc_q   <= 1'b0;
            done_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tc_q   <= tc_d;
            done_q <= done_d;
            ovf_q  <= ovf_d;
        end
    end

    assign cnt_o  = cnt_q;
    assign tc_o   = tc_q;
    assign done_o = done_q;
    assign ovf_o  = ovf_q;

endmodule

// File: rtl/counter_multi.sv
// Multi-channel counter: CH_NUM independent counter_ch instances on one clock.
// This level only slices the packed channel vectors.
module counter_multi
    import counter_pkg::*;
#(
    parameter int CNT_WIDTH = 8,
    parameter int CH_NUM    = 4
) (
    input  logic                          cnt_clk,
    input  logic                          cnt_rst_n,
    input  logic [CH_NUM-1:0]             cnt_en,
    input  logic [CH_NUM-1:0]             cnt_clr,
    input  logic [CH_NUM-1:0]             cnt_load,
    input  logic [CH_NUM*CNT_WIDTH-1:0]   cnt_load_val,
    input  logic [CH_NUM-1:0]             cnt_dir,
    input  logic [CH_NUM*CNT_MODE_W-1:0]  cnt_mode,
    input  logic [CH_NUM*CNT_WIDTH-1:0]   cnt_max,
    output logic [CH_NUM*CNT_WIDTH-1:0]   cnt_o,
    output logic [CH_NUM-1:0]             cnt_tc,
    output logic [CH_NUM-1:0]             cnt_done,
    output logic [CH_NUM-1:0]             cnt_ovf
);

    for (genvar ch = 0; ch < CH_NUM; ch++) begin : g_ch
        counter_ch #(
            .W (CNT_WIDTH)
        ) u_ch (
            .clk_i      (cnt_clk),
            .rst_ni     (cnt_rst_n),
            .en_i       (cnt_en[ch]),
            .clr_i      (cnt_clr[ch]),
            .load_i     (cnt_load[ch]),
            .load_val_i (cnt_load_val[ch*CNT_WIDTH +: CNT_WIDTH]),
            .dir_i      (cnt_dir[ch]),
            .mode_i     (cnt_mode_e'(cnt_mode[ch*CNT_MODE_W +: CNT_MODE_W])),
            .max_i      (cnt_max[ch*CNT_WIDTH +: CNT_WIDTH]),
            .cnt_o      (cnt_o[ch*CNT_WIDTH +: CNT_WIDTH]),
            .tc_o       (cnt_tc[ch]),
            .done_o     (cnt_done[ch]),
            .ovf_o      (cnt_ovf[ch])
        );
    end

endmodule

// File: tb/tb_counter_multi.sv
// Scoreboard bench for counter_multi: stimulus queues hand-computed
// per-channel expectations, a monitor compares them after each edge.
module tb_counter_multi;

    localparam int W = 8;
    localparam int N = 4;

    logic           clk;
    logic           rst_n;
    logic [N-1:0]   en, clr, load, dir;
    logic [N*W-1:0] load_val, max;
    logic [N*2-1:0] mode;
    logic [N*W-1:0] cnt;
    logic [N-1:0]   tc, done, ovf;

    typedef struct {
        int ch;
        int c;
        int t;
        int d;
        int o;
        string nm;
    } exp_t;

    exp_t q[$];
    int n_cmp = 0;
    int n_bad = 0;

    counter_multi #(.CNT_WIDTH(W), .CH_NUM(N)) dut (
        .cnt_clk      (clk),
        .cnt_rst_n    (rst_n),
        .cnt_en       (en),
        .cnt_clr      (clr),
        .cnt_load     (load),
        .cnt_load_val (load_val),
        .cnt_dir      (dir),
        .cnt_mode     (mode),
        .cnt_max      (max),
        .cnt_o        (cnt),
        .cnt_tc       (tc),
        .cnt_done     (done),
        .cnt_ovf      (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(string nm, int got, int want);
        n_cmp++;
        if (got != want) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, got, want);
        end
    endtask

    task automatic chk_ch(exp_t e);
        int gc;
        gc = int'(cnt[e.ch*W +: W]);
        chk($sformatf("%s ch%0d cnt", e.nm, e.ch), gc, e.c);
        chk($sformatf("%s ch%0d tc", e.nm, e.ch), int'(tc[e.ch]), e.t);
        chk($sformatf("%s ch%0d done", e.nm, e.ch), int'(done[e.ch]), e.d);
        chk($sformatf("%s ch%0d ovf", e.nm, e.ch), int'(ovf[e.ch]), e.o);
    endtask

    // monitor: everything queued before an edge is due right after it
    always @(posedge clk) begin
        #1;
        while (q.size() > 0) chk_ch(q.pop_front());
    end

    task automatic expect_ch(string nm, int ch, int c, int t, int d, int o);
        exp_t e;
        e.nm = nm; e.ch = ch; e.c = c; e.t = t; e.d = d; e.o = o;
        q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic cfg(int ch, int md, int up, int mx);
        mode[ch*2 +: 2] = md[1:0];
        dir[ch] = up[0];
        max[ch*W +: W] = mx[W-1:0];
    endtask

    task automatic all_zero(string nm);
        chk({nm, " cnt"}, int'(cnt), 0);
        chk({nm, " tc"}, int'(tc), 0);
        chk({nm, " done"}, int'(done), 0);
        chk({nm, " ovf"}, int'(ovf), 0);
    endtask

    initial begin
        rst_n = 1'b0;
        en = '0; clr = '0; load = '0; dir = '0;
        load_val = '0; max = '0; mode = '0;
        repeat (2) @(negedge clk);
        all_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // 1: ch0 WRAP up max 9
        cfg(0, 0, 1, 9);
        en[0] = 1'b1;
        begin
            int ec[12] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2};
            for (int i = 0; i < 12; i++) begin
                expect_ch("wrap", 0, ec[i], (i == 9) ? 1 : 0, 0,
                          (i >= 9) ? 1 : 0);
                tick();
            end
        end
        en[0] = 1'b0;

        // 2: ch1 SAT down, load 3
        cfg(1, 1, 0, 9);
        load[1] = 1'b1;
        load_val[1*W +: W] = 8'd3;
        expect_ch("satld", 1, 3, 0, 0, 0);
        tick();
        load[1] = 1'b0;
        en[1] = 1'b1;
        begin
            int ec[6] = '{2, 1, 0, 0, 0, 0};
            for (int i = 0; i < 6; i++) begin
                expect_ch("sat", 1, ec[i], (i >= 3) ? 1 : 0, 0,
                          (i >= 3) ? 1 : 0);
                tick();
            end
        end
        en[1] = 1'b0;

        // 3: ch2 ONESHOT up max 4
        cfg(2, 2, 1, 4);
        en[2] = 1'b1;
        begin
            int ec[8] = '{1, 2, 3, 4, 4, 4, 4, 4};
            for (int i = 0; i < 8; i++) begin
                expect_ch("oneshot", 2, ec[i], (i == 4) ? 1 : 0,
                          (i >= 4) ? 1 : 0, (i >= 4) ? 1 : 0);
                tick();
            end
        end
        load[2] = 1'b1;
        load_val[2*W +: W] = 8'd2;
        expect_ch("osload", 2, 2, 0, 0, 1);
        tick();
        load[2] = 1'b0;
        expect_ch("osrun", 2, 3, 0, 0, 1);
        tick();
        expect_ch("osrun", 2, 4, 0, 0, 1);
        tick();
        en[2] = 1'b0;

        // 4: ch3 priority and clamp
        cfg(3, 0, 1, 50);
        clr[3] = 1'b1; load[3] = 1'b1; en[3] = 1'b1;
        load_val[3*W +: W] = 8'd7;
        expect_ch("clrpri", 3, 0, 0, 0, 0);
        tick();
        clr[3] = 1'b0;
        expect_ch("loadpri", 3, 7, 0, 0, 0);
        tick();
        en[3] = 1'b0;
        load_val[3*W +: W] = 8'd200;
        expect_ch("clamp", 3, 50, 0, 0, 0);
        tick();
        load[3] = 1'b0;
        max[3*W +: W] = 8'd0;
        en[3] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            expect_ch("max0", 3, 0, 1, 0, 1);
            tick();
        end
        en[3] = 1'b0;
        clr[3] = 1'b1;
        expect_ch("clr3", 3, 0, 0, 0, 0);
        tick();
        clr[3] = 1'b0;

        // 5: async reset mid-count
        clr[0] = 1'b1;
        expect_ch("clr0", 0, 0, 0, 0, 0);
        tick();
        clr[0] = 1'b0;
        en[0] = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            expect_ch("pre", 0, i, 0, 0, 0);
            tick();
        end
        en[0] = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        all_zero("rstasync");
        tick();
        all_zero("rsthold");
        rst_n = 1'b1;
        en[0] = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            expect_ch("post", 0, i, 0, 0, 0);
            for (int c = 1; c < N; c++) expect_ch("idle", c, 0, 0, 0, 0);
            tick();
        end
        en[0] = 1'b0;

        tick();
        chk("queue drained", q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
